// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared op encodings, latency default and result selection for the multiply issue controller
package mul_pkg;

    localparam int XLEN        = 32;
    localparam int MUL_LAT_DEF = 5;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    // MULHSU runs on the unsigned multiplier; a negative rs1 needs b removed from the high word.
    function automatic logic [XLEN-1:0] mul_select(
        input mul_op_e           op,
        input logic [2*XLEN-1:0] r,
        input logic              a_sign,
        input logic [XLEN-1:0]   b
    );
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] res;
        hi = r[2*XLEN-1:XLEN];
        case (op)
            OP_MUL:    res = r[XLEN-1:0];
            OP_MULHSU: res = hi - (a_sign ? b : '0);
            default:   res = hi;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// rtl/mul_issue_ctrl_if.sv - request, multiplier and result signal bundle for mul_issue_ctrl
interface mul_issue_ctrl_if #(
    parameter int DATA_WIDH = 32,
    parameter int TAG_W     = 5
);

    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             in_op;
    logic [DATA_WIDH-1:0]   in_a;
    logic [DATA_WIDH-1:0]   in_b;
    logic [TAG_W-1:0]       in_tag;
    logic                   flush;
    logic [DATA_WIDH-1:0]   mul_a;
    logic [DATA_WIDH-1:0]   mul_b;
    logic                   mul_is_unsigned;
    logic [2*DATA_WIDH-1:0] mul_r;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDH-1:0]   out_data;
    logic [TAG_W-1:0]       out_tag;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, flush, mul_r, out_ready,
        output in_ready, mul_a, mul_b, mul_is_unsigned, out_valid, out_data, out_tag
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, flush, mul_r, out_ready,
        input  in_ready, mul_a, mul_b, mul_is_unsigned, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/mul_res_fifo.sv
// rtl/mul_res_fifo.sv - synchronous result buffer with clear; read data reads as zero while empty
module mul_res_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign do_rd = rd_en && !empty;
    // A write into a full buffer is fine when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = empty ? '0 : mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_wr && !do_rd) begin
                count <= count + CNT_W'(1);
            end else if (!do_wr && do_rd) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - multiply issue/retire controller around an external pipelined multiplier (option: MUL_ISSUE_PERF_EN)
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int DATA_WIDH    = XLEN,
    parameter int MUL_LAT      = MUL_LAT_DEF,
    parameter int TAG_W        = 5,
    parameter int RESULT_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    mul_issue_ctrl_if.slave bus
`ifdef MUL_ISSUE_PERF_EN
    ,
    output logic [31:0]     perf_done_cnt,
    output logic [31:0]     perf_full_cnt
`endif
);

    localparam int CNT_W = $clog2(RESULT_DEPTH + 1);
    localparam int ENT_W = TAG_W + DATA_WIDH;

    typedef struct packed {
        logic                 valid;
        mul_op_e              op;
        logic [TAG_W-1:0]     tag;
        logic [DATA_WIDH-1:0] b;
        logic                 a_sign;
    } track_t;

    track_t               track [MUL_LAT];
    track_t               head;
    logic [CNT_W-1:0]     outstanding;
    logic                 accept;
    logic                 pop;
    logic                 res_wr;
    logic [DATA_WIDH-1:0] res_data;
    logic [ENT_W-1:0]     fifo_rd;
    logic                 fifo_empty;

    assign bus.mul_a           = bus.in_a;
    assign bus.mul_b           = bus.in_b;
    assign bus.mul_is_unsigned = (mul_op_e'(bus.in_op) != OP_MULH);

    // Outstanding covers both in-flight and buffered ops, so the buffer can never overflow.
    assign bus.in_ready = (outstanding < CNT_W'(RESULT_DEPTH)) && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign pop          = bus.out_valid && bus.out_ready;

    assign head     = track[MUL_LAT-1];
    assign res_wr   = head.valid && !bus.flush;
    assign res_data = mul_select(head.op, bus.mul_r, head.a_sign, head.b);

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                track[i].valid <= 1'b0;
            end
        end else begin
            track[0] <= '{valid:  accept,
                          op:     mul_op_e'(bus.in_op),
                          tag:    bus.in_tag,
                          b:      bus.in_b,
                          a_sign: bus.in_a[DATA_WIDH-1]};
            for (int i = 1; i < MUL_LAT; i++) begin
                track[i] <= track[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            outstanding <= '0;
        end else if (accept && !pop) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (!accept && pop) begin
            outstanding <= outstanding - CNT_W'(1);
        end
    end

    mul_res_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (RESULT_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.flush),
        .wr_en   (res_wr),
        .wr_data ({head.tag, res_data}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .empty   (fifo_empty)
    );

    assign bus.out_valid              = !fifo_empty;
    assign {bus.out_tag, bus.out_data} = fifo_rd;

`ifdef MUL_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_done_cnt <= '0;
            perf_full_cnt <= '0;
        end else begin
            if (pop) begin
                perf_done_cnt <= perf_done_cnt + 32'd1;
            end
            if (bus.in_valid && !bus.in_ready) begin
                perf_full_cnt <= perf_full_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WIDH, 32, operand width; MUL_LAT, 5, multiplier input-to-result latency in cycles; TAG_W, 5, destination tag width; RESULT_DEPTH, 8, result buffer entries (must be >= MUL_LAT).
REQ-002 SHALL have ports, clock and reset first:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, synchronous, active-high reset.
- in_valid, in, 1, request valid.
- in_ready, out, 1, request accepted when high together with in_valid.
- in_op, in, 2, operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_a, in_b, in, DATA_WIDH each, operands (rs1, rs2).
- in_tag, in, TAG_W, destination tag.
- flush, in, 1, kill all in-flight and buffered ops.
- mul_a, mul_b, out, DATA_WIDH each, operands to the pipelined multiplier.
- mul_is_unsigned, out, 1, signedness to the multiplier.
- mul_r, in, 2*DATA_WIDH, multiplier product.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts the result.
- out_data, out, DATA_WIDH, result.
- out_tag, out, TAG_W, result tag.

Function
REQ-003 SHALL drive mul_a=in_a and mul_b=in_b combinationally; mul_is_unsigned SHALL be 0 for MULH and 1 for MUL, MULHSU and MULHU.
REQ-004 SHALL assert in_ready when outstanding < RESULT_DEPTH and flush=0; outstanding = in-flight ops + buffered results.
REQ-005 SHALL carry a MUL_LAT-deep tracking shift register per accepted op: {valid, op, tag, in_b, in_a[31]}; a non-accepted cycle SHALL insert valid=0.
REQ-006 SHALL compute the result when a valid tracking entry reaches stage MUL_LAT, aligned with mul_r:
- MUL: mul_r[31:0].
- MULH, MULHU: mul_r[63:32].
- MULHSU: mul_r[63:32] - (a_sign ? b : 0), modulo 2^32.
REQ-007 SHALL write the result and tag into a FIFO at the end of that cycle; the FIFO cannot overflow because of REQ-004.
REQ-008 Latency: an op accepted in cycle N SHALL present out_valid in cycle N+MUL_LAT+1 when the FIFO is empty.
REQ-009 out_valid SHALL equal FIFO non-empty; the head SHALL pop on out_valid && out_ready; results SHALL stay in acceptance order.
REQ-010 out_data and out_tag SHALL stay stable while out_valid=1 and out_ready=0.
REQ-011 Simultaneous accept and pop SHALL leave outstanding unchanged; simultaneous FIFO write and pop at full or empty SHALL be legal.
REQ-012 flush SHALL take priority over in_valid: no accept that cycle; next cycle all tracking valids=0, FIFO empty, outstanding=0, out_valid=0.

Reset
REQ-013 On rst, SHALL clear tracking valids, FIFO pointers and count, and outstanding; out_valid=0, in_ready=1 in the cycle after rst deasserts, out_data=0, out_tag=0. Ops in flight when rst asserts SHALL be discarded.

Configuration
REQ-014 With MUL_ISSUE_PERF_EN defined, SHALL add outputs perf_done_cnt[31:0] (+1 per pop) and perf_full_cnt[31:0] (+1 per cycle with in_valid=1 and in_ready=0), both wrapping and cleared by rst only. Without the macro, these ports and counters SHALL be absent.

Structure
REQ-015 SHALL place the op encoding constants, MUL_LAT default and the result-selection function in shared package mul_pkg.
REQ-016 SHALL implement the result buffer as sub-module mul_res_fifo (synchronous, parameterised width and depth).

Verification
REQ-017 MUL, a=7, b=6, tag=3, out_ready=1 -> out_data=42, out_tag=3, out_valid in cycle N+6.
REQ-018 a=b=0xFFFFFFFF: MULH -> 0x00000000; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
REQ-019 out_ready=0, in_valid=1 with 10 ops (tags 0..9) -> in_ready low after 8 accepts; release out_ready -> tags 0..9 delivered in order, none lost.
REQ-020 flush two cycles after accepting 3 ops -> none of them appear; next MUL 3*5 -> 15 after 6 cycles.
REQ-021 rst asserted with 4 ops in flight -> out_valid=0 for 10 cycles; in_ready=1 after rst deasserts.
REQ-022 (MUL_ISSUE_PERF_EN) the REQ-019 run -> perf_done_cnt=10, perf_full_cnt = number of stalled cycles.
